ex_mem_pipe: RTL and testbench
==============================

Name: ex_mem_pipe

Overview:
Elastic pipeline register between the EX stage and the MEM stage of the 32-bit MIPS core. It captures the ALU result, the store data, the memory control bits and the writeback control from EX, and presents them to MEM. It uses a valid/ready handshake backed by a 2-entry skid buffer, so the handshake path carries no combinational ready path from MEM back to EX. It also supplies an EX->EX forwarding source, a synchronous flush for branch/exception squash, and a saturating stall counter for debug.

Parameters:
DATA_W, 32, width of alu_out and write_data
REG_W, 5, width of destination register index
CNT_W, 16, width of stall counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  EX presents an instruction
in_ready  output  1  block can accept (registered)
in_alu_out  input  DATA_W  ALU result / memory address
in_write_data  input  DATA_W  store data (rt value)
in_mem_read  input  1  load
in_mem_write  input  1  store
in_reg_write  input  1  writes register file
in_mem_to_reg  input  1  writeback selects memory data
in_write_reg  input  REG_W  destination register
out_valid  output  1  head entry valid toward MEM
out_ready  input  1  MEM consumes head this cycle
out_alu_out, out_write_data, out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg, out_write_reg  output  as inputs  head entry fields
fwd_valid  output  1  head is forwardable (out_valid & reg_write & !mem_read & write_reg!=0)
fwd_reg  output  REG_W  head destination register
fwd_data  output  DATA_W  head alu_out
stall_cnt  output  CNT_W  cycles with out_valid & !out_ready, saturating

Behaviour:
- Storage: main entry (drives out_*) plus skid entry, each with a valid bit; FIFO order is strict.
- Accept occurs when in_valid & in_ready & !flush. Pop occurs when out_valid & out_ready & !flush.
- in_ready is a register equal to !skid_valid. It updates on every edge with the next-state skid_valid.
- Transitions:
  - Main empty, accept: input goes into main.
  - Main full, pop and accept: input goes into main.
  - Main full, no pop, accept: input goes into skid.
  - Main full, pop, skid full: skid moves into main, skid cleared.
  - Main full, pop, skid empty, no accept: main cleared.
- Accept while skid full cannot happen because in_ready=0; in_valid in that case is ignored.
- Latency: an accepted instruction appears on out_* 1 cycle later when the buffer was empty. Throughput is 1 per cycle while out_ready=1.
- Payload held while out_valid & !out_ready must remain stable.
- out_* fields when out_valid=0: hold the last value; they are don't-care to MEM, except that out_mem_read and out_mem_write are forced 0 when !out_valid so MEM never sees a spurious access.
- Flush, on the next edge:
  - main_valid=0, skid_valid=0, in_ready=1.
  - An input presented in the flush cycle is dropped.
  - A pop in the flush cycle does not count.
  - stall_cnt is unaffected.
- Reset (asynchronous assert, sync deassert assumed by top):
  - out_valid=0, in_ready=1, all out_* payload=0, fwd_valid=0, stall_cnt=0, skid_valid=0.
  - Reset mid-transfer discards all entries.
- stall_cnt increments by 1 on each edge with out_valid & !out_ready & !flush, and saturates at 2^CNT_W-1 with no wrap.
- fwd_* is combinational from the main entry only. The skid entry is never forwarded; EX stalls via in_ready.

Test Plan:
- Reset with rst=1 mid-stream: out_valid=0, in_ready=1, stall_cnt=0 asynchronously. After release, push alu_out=0x10, reg_write=1, write_reg=8: out_valid=1 next cycle, fwd_valid=1, fwd_data=0x10.
- Stream 4 ops with out_ready=1: they appear on 4 consecutive cycles in order, and in_ready stays 1.
- Back-pressure: hold out_ready=0 and push A then B. B lands in skid, in_ready=0 on the next cycle, and C is held by EX. Raise out_ready: outputs are A, B, C in order, with no loss or duplication.
- Load at head (mem_read=1, reg_write=1, write_reg=9): fwd_valid=0. write_reg=0 with reg_write=1: fwd_valid=0.
- Flush with both entries full and in_valid=1: next cycle out_valid=0, in_ready=1, and out_mem_read and out_mem_write both 0. The flushed-cycle input never appears.
- Hold out_ready=0 with out_valid=1 for 70000 cycles (CNT_W=16): stall_cnt stops at 65535.

Source files
------------

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: elastic EX->MEM pipeline register for the 32-bit MIPS core.
// A main entry drives the MEM-side outputs and a skid entry absorbs one extra
// instruction, so in_ready is purely registered and never depends on out_ready
// in the same cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous squash of both held entries
//   in_valid/in_ready   EX-side handshake (in_ready registered)
//   in_*                EX payload: alu result, store data, mem/wb control, dest reg
//   out_valid/out_ready MEM-side handshake for the head entry
//   out_*               head entry payload (mem_read/mem_write gated by out_valid)
//   fwd_valid/reg/data  EX->EX forwarding source from the main entry only
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
module ex_mem_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [REG_W-1:0]  in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_write_data,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [REG_W-1:0]  out_write_reg,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] writeData;
    logic              memRead;
    logic              memWrite;
    logic              regWrite;
    logic              memToReg;
    logic [REG_W-1:0]  writeReg;
  } entry_t;

  entry_t mainQ, mainN;
  entry_t skidQ, skidN;
  entry_t inEntry;
  logic   mainValid, mainValidN;
  logic   skidValid, skidValidN;
  logic   inReadyQ;
  logic   accept, pop;
  logic [CNT_W-1:0] stallQ;

  assign accept = in_valid & inReadyQ & ~flush;
  assign pop    = mainValid & out_ready & ~flush;

  always_comb begin
    inEntry.aluOut    = in_alu_out;
    inEntry.writeData = in_write_data;
    inEntry.memRead   = in_mem_read;
    inEntry.memWrite  = in_mem_write;
    inEntry.regWrite  = in_reg_write;
    inEntry.memToReg  = in_mem_to_reg;
    inEntry.writeReg  = in_write_reg;
  end

  // Payload registers keep their last contents when an entry is invalidated;
  // only the valid bits are cleared on pop-to-empty or flush.
  always_comb begin
    mainN      = mainQ;
    skidN      = skidQ;
    mainValidN = mainValid;
    skidValidN = skidValid;
    if (flush) begin
      mainValidN = 1'b0;
      skidValidN = 1'b0;
    end else if (!mainValid) begin
      if (accept) begin
        mainN      = inEntry;
        mainValidN = 1'b1;
      end
    end else if (pop) begin
      if (skidValid) begin
        // in_ready is low whenever skid is full, so no accept can collide here
        mainN      = skidQ;
        skidValidN = 1'b0;
      end else if (accept) begin
        mainN = inEntry;
      end else begin
        mainValidN = 1'b0;
      end
    end else if (accept) begin
      skidN      = inEntry;
      skidValidN = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mainQ     <= '0;
      skidQ     <= '0;
      mainValid <= 1'b0;
      skidValid <= 1'b0;
      inReadyQ  <= 1'b1;
    end else begin
      mainQ     <= mainN;
      skidQ     <= skidN;
      mainValid <= mainValidN;
      skidValid <= skidValidN;
      inReadyQ  <= ~skidValidN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallQ <= '0;
    end else if (mainValid && !out_ready && !flush && stallQ != '1) begin
      stallQ <= stallQ + CNT_W'(1);
    end
  end

  assign in_ready       = inReadyQ;
  assign out_valid      = mainValid;
  assign out_alu_out    = mainQ.aluOut;
  assign out_write_data = mainQ.writeData;
  assign out_mem_read   = mainValid & mainQ.memRead;
  assign out_mem_write  = mainValid & mainQ.memWrite;
  assign out_reg_write  = mainQ.regWrite;
  assign out_mem_to_reg = mainQ.memToReg;
  assign out_write_reg  = mainQ.writeReg;

  // Loads are not forwardable from here: their data only exists after MEM.
  assign fwd_valid = mainValid & mainQ.regWrite & ~mainQ.memRead & (mainQ.writeReg != '0);
  assign fwd_reg   = mainQ.writeReg;
  assign fwd_data  = mainQ.aluOut;
  assign stall_cnt = stallQ;

endmodule

// File: tb/tb_ex_mem_pipe.sv
module tb_ex_mem_pipe;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic        mr;
    logic        mw;
    logic        rw;
    logic        m2r;
    logic [4:0]  wr;
  } pay_t;

  typedef struct {
    logic iv;
    pay_t p;
    logic ordy;
    logic fl;
    logic eV;
    logic eR;
    logic eF;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_out;
  logic [31:0] in_write_data;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [4:0]  in_write_reg;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_alu_out;
  logic [31:0] out_write_data;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_reg_write;
  logic        out_mem_to_reg;
  logic [4:0]  out_write_reg;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic [15:0] stall_cnt;

  ex_mem_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_write_data(in_write_data),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_write_reg(in_write_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_out(out_alu_out), .out_write_data(out_write_data),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
    .out_write_reg(out_write_reg),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int   nTests = 0;
  int   nFail  = 0;
  pay_t sb[$];      // scoreboard: in-flight entries, head = what MEM should see
  int   stallExp = 0;

  function automatic pay_t mk(input logic [31:0] alu, input logic [31:0] wd,
                              input logic mr, input logic mw, input logic rw,
                              input logic m2r, input logic [4:0] wr);
    pay_t p;
    p.alu = alu; p.wd = wd; p.mr = mr; p.mw = mw; p.rw = rw; p.m2r = m2r; p.wr = wr;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutputs();
    pay_t h;
    chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
    chk("stall_cnt", 32'(stall_cnt), 32'(stallExp));
    if (sb.size() > 0) begin
      h = sb[0];
      chk("out_alu_out", out_alu_out, h.alu);
      chk("out_write_data", out_write_data, h.wd);
      chk("out_mem_read", 32'(out_mem_read), 32'(h.mr));
      chk("out_mem_write", 32'(out_mem_write), 32'(h.mw));
      chk("out_reg_write", 32'(out_reg_write), 32'(h.rw));
      chk("out_mem_to_reg", 32'(out_mem_to_reg), 32'(h.m2r));
      chk("out_write_reg", 32'(out_write_reg), 32'(h.wr));
      chk("fwd_valid", 32'(fwd_valid), 32'(h.rw && !h.mr && h.wr != 5'd0));
      chk("fwd_reg", 32'(fwd_reg), 32'(h.wr));
      chk("fwd_data", fwd_data, h.alu);
    end else begin
      chk("idle_mem_read", 32'(out_mem_read), 32'd0);
      chk("idle_mem_write", 32'(out_mem_write), 32'd0);
      chk("idle_fwd_valid", 32'(fwd_valid), 32'd0);
    end
  endtask

  // Drive one cycle of stimulus, advance the reference model at the edge,
  // then compare all outputs 1 time unit after the edge.
  task automatic step(input logic iv, input pay_t p, input logic ordy, input logic fl);
    logic acc, pp;
    in_valid      = iv;
    in_alu_out    = p.alu;
    in_write_data = p.wd;
    in_mem_read   = p.mr;
    in_mem_write  = p.mw;
    in_reg_write  = p.rw;
    in_mem_to_reg = p.m2r;
    in_write_reg  = p.wr;
    out_ready     = ordy;
    flush         = fl;
    acc = iv && (sb.size() < 2) && !fl;
    pp  = (sb.size() > 0) && ordy && !fl;
    @(posedge clk);
    if ((sb.size() > 0) && !ordy && !fl && stallExp < 65535) stallExp++;
    if (fl) sb.delete();
    else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back(p);
    end
    #1;
    checkOutputs();
  endtask

  vec_t vecs[15];
  pay_t none;

  initial begin
    none = '0;
    // stream of 4, then back-pressure A/B/C, then non-forwardable heads
    vecs[0]  = '{1'b1, mk(32'h100, 32'h200, 0, 1, 0, 0, 5'd0),  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, mk(32'h101, 32'h201, 0, 0, 1, 0, 5'd3),  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, mk(32'h102, 32'h202, 0, 0, 1, 0, 5'd4),  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, mk(32'h103, 32'h203, 0, 0, 1, 0, 5'd5),  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, none,                                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, mk(32'hA0, 32'hA1, 0, 0, 1, 0, 5'd10),   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, mk(32'hB0, 32'hB1, 0, 0, 1, 0, 5'd11),   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, mk(32'hC0, 32'hC1, 0, 0, 1, 0, 5'd12),   1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, mk(32'hC0, 32'hC1, 0, 0, 1, 0, 5'd12),   1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, mk(32'hC0, 32'hC1, 0, 0, 1, 0, 5'd12),   1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{1'b0, none,                                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, mk(32'h300, 32'h0, 1, 0, 1, 1, 5'd9),    1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, none,                                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, mk(32'h400, 32'h0, 0, 0, 1, 0, 5'd0),    1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b0, none,                                    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_out = '0; in_write_data = '0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_write_reg = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutputs();
    chk("reset_alu_out", out_alu_out, 32'd0);
    chk("reset_write_reg", 32'(out_write_reg), 32'd0);

    // fill both entries and stall, then reset asynchronously mid-cycle
    step(1'b1, mk(32'h55, 32'h66, 1, 0, 1, 1, 5'd7), 1'b0, 1'b0);
    step(1'b1, mk(32'h77, 32'h88, 0, 1, 0, 0, 5'd0), 1'b0, 1'b0);
    step(1'b0, none, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    sb.delete(); stallExp = 0;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    chk("async_rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("async_rst_alu_out", out_alu_out, 32'd0);
    chk("async_rst_mem_read", 32'(out_mem_read), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step(1'b1, mk(32'h10, 32'h0, 0, 0, 1, 0, 5'd8), 1'b0, 1'b0);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("first_fwd_data", fwd_data, 32'h10);
    step(1'b0, none, 1'b1, 1'b0);

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].iv, vecs[i].p, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].eV));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eR));
      chk($sformatf("vec%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].eF));
    end

    // flush with both entries full (load at head, store in skid) and a new input
    step(1'b1, mk(32'h500, 32'h0, 1, 0, 1, 1, 5'd6), 1'b0, 1'b0);
    step(1'b1, mk(32'h600, 32'h61, 0, 1, 0, 0, 5'd0), 1'b0, 1'b0);
    chk("pre_flush_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, mk(32'hDD, 32'hDE, 0, 1, 1, 0, 5'd13), 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_mem_read", 32'(out_mem_read), 32'd0);
    chk("flush_mem_write", 32'(out_mem_write), 32'd0);
    step(1'b0, none, 1'b1, 1'b0);
    step(1'b0, none, 1'b1, 1'b0);

    // long stall: counter must stop at 2^16-1
    step(1'b1, mk(32'h700, 32'h701, 0, 0, 1, 0, 5'd2), 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    stallExp = (stallExp + 100 > 65535) ? 65535 : stallExp + 100;
    chk("stall_cnt_mid", 32'(stall_cnt), 32'(stallExp));
    repeat (69900) @(posedge clk);
    #1;
    stallExp = 65535;
    checkOutputs();
    chk("stall_cnt_saturated", 32'(stall_cnt), 32'd65535);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
